piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//   Parallel-in serial-out frame transmitter; source end of the siso serial link.
//   Accepts a WIDTH-bit word over a valid/ready handshake and sends it on sOut:
//   one start bit (1), WIDTH data bits MSB first, one stop bit (0).
//   Line idles at 0, the same levels the siso stage consumes.
//   Sits upstream of siso/SIPO stages and drives their sIn input.
// PARAMETERS
//   WIDTH  8  data bits per frame; legal range 2..32; frame length = WIDTH+2 cycles
// PORTS
//   clk         in   1      clock; all state changes on rising edge
//   rst         in   1      reset: synchronous, active-high
//   load_valid  in   1      pData is valid and ready to be sent
//   load_ready  out  1      transmitter can accept a word this cycle
//   pData       in   WIDTH  word to transmit; sampled only on an accepted handshake
//   sOut        out  1      serial line, registered
//   busy        out  1      frame in progress (state != IDLE), registered
//   done        out  1      one-cycle pulse, high during the stop-bit cycle
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, sOut=0, busy=0, done=0, bit counter=0,
//     shift register=0; load_ready forced 0 while rst=1.
//   FSM states IDLE, START, DATA, STOP; state and shift register are registered.
//   load_ready = !rst && (state==IDLE || state==STOP), combinational from state.
//   Accept = load_valid && load_ready at a rising edge; pData copied to shift reg.
//   IDLE : sOut=0. Accept -> START. No accept -> stay IDLE.
//   START: sOut=1 for exactly one cycle; -> DATA, bit counter = WIDTH-1.
//   DATA : sOut = shreg[WIDTH-1]; shreg shifts left by 1 and counter decrements
//          each edge. After WIDTH cycles in DATA, go to STOP (counter==0 -> STOP).
//   STOP : sOut=0, done=1 for this one cycle. Accept -> START (back-to-back,
//          no idle gap, period exactly WIDTH+2 cycles). No accept -> IDLE.
//   Latency: accept at edge k -> start bit visible after edge k; data bit i (MSB=0)
//     visible after edge k+1+i; stop bit after edge k+WIDTH+1; IDLE after k+WIDTH+2
//     unless a new word is accepted at that edge.
//   load_valid during START/DATA: ignored (ready=0); the word must be held by the
//     source until accepted. pData changes while not accepted have no effect.
//   Reset mid-frame: frame aborted at that edge, sOut=0 next cycle, no done pulse,
//     partially sent word discarded; load_ready=1 in the first cycle after rst=0.
//   done and busy: busy=1 in START/DATA/STOP; done only in STOP, never in reset.
//   Bit counter width $clog2(WIDTH); no wrap beyond 0 (DATA exits at 0).
// TESTING (clock period 200 ns, rst held high for 2 cycles first)
//   1 Reset/idle: rst 1->0, load_valid=0 -> sOut=0, busy=0, done=0, load_ready=1.
//   2 Single frame: pData=8'hA5 accepted -> sOut over 10 cycles = 1,1,0,1,0,0,1,0,1,0;
//     done=1 only on the final (stop) cycle; busy=1 for all 10 cycles.
//   3 Back-to-back: load_valid held with 8'hFF then 8'h00 -> second start bit
//     directly follows first stop bit; seq 1,11111111,0,1,00000000,0; 2 done pulses.
//   4 Ignore while busy: assert load_valid with 8'h3C during DATA -> load_ready=0,
//     frame in progress unchanged; 8'h3C sent only after the STOP-cycle accept.
//   5 Reset mid-frame: rst=1 for 1 cycle after 3rd data bit of 8'hA5 -> sOut=0 next
//     cycle, no done pulse, busy=0, load_ready=1 after release.
//   6 WIDTH=4 instance: pData=4'h9 -> sOut = 1,1,0,0,1,0 over 6 cycles, then idle 0.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit (1), WIDTH data bits MSB
// first, stop bit (0); the line idles low.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pData,
    output logic             sOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             sout_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;

    // A new word is taken when idle, or during the stop bit for gapless back-to-back frames.
    always_comb begin
        load_ready = 1'b0;
        if (rst) begin
            load_ready = 1'b0;
        end else if ((state_r == IDLE) || (state_r == STOP)) begin
            load_ready = 1'b1;
        end else begin
            load_ready = 1'b0;
        end
    end

    assign accept_s = load_valid && load_ready;

    // Frame sequencer: the line value for each state is registered together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            sout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, STOP: begin
                    if (accept_s) begin
                        state_r <= START;
                        shreg_r <= pData;
                        sout_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        sout_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                START: begin
                    state_r <= DATA;
                    cnt_r   <= CNT_LAST;
                    sout_r  <= shreg_r[WIDTH-1];
                    shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                end
                DATA: begin
                    // Counter reaching zero means the last data bit is on the line now.
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= STOP;
                        sout_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DATA;
                        cnt_r   <= cnt_r - CNT_ONE;
                        sout_r  <= shreg_r[WIDTH-1];
                        shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shreg_r <= {WIDTH{1'b0}};
                    cnt_r   <= CNT_ZERO;
                    sout_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sOut = sout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed frames on WIDTH=8 and WIDTH=4 instances plus
// randomized traffic against a queue-of-pending-line-bits reference model.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] pData;
    logic       sOut, busy, done;

    logic       load_valid4;
    logic       load_ready4;
    logic [3:0] pData4;
    logic       sOut4, busy4, done4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: bits still to appear on the line, one per future edge.
    bit   m_pend[$];
    logic m_sout, m_busy, m_done, m_acc;

    always #100 clk = ~clk;

    piso_tx #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .pData(pData), .sOut(sOut), .busy(busy), .done(done)
    );

    piso_tx #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .load_valid(load_valid4), .load_ready(load_ready4),
        .pData(pData4), .sOut(sOut4), .busy(busy4), .done(done4)
    );

    function automatic bit frame_bit(input logic [31:0] word, input int j, input int w);
        if (j == 0) return 1'b1;
        if (j == w + 1) return 1'b0;
        return word[w - j];
    endfunction

    function automatic logic m_ready();
        return !rst && (m_pend.size() == 0);
    endfunction

    // Advance one clock: update the model with the inputs present at the edge, end on negedge.
    task automatic step();
        @(posedge clk);
        m_acc = 1'b0;
        if (rst) begin
            m_pend.delete();
            m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            if (load_valid && (m_pend.size() == 0)) begin
                m_acc = 1'b1;
                for (int j = 0; j < 10; j++) m_pend.push_back(frame_bit({24'd0, pData}, j, 8));
            end
            if (m_pend.size() > 0) begin
                m_sout = m_pend.pop_front();
                m_busy = 1'b1;
                m_done = (m_pend.size() == 0);
            end else begin
                m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; pData = 8'h00; load_valid4 = 1'b0; pData4 = 4'h0;
        step(); step();
        #1;
        n_checks++;
        if ({sOut, busy, done, load_ready} !== 4'b0000)
            $display("FAIL reset_hold: got %b want 0000", {sOut, busy, done, load_ready});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({sOut, busy, done, load_ready} !== 4'b0001)
            $display("FAIL reset_release: got %b want 0001", {sOut, busy, done, load_ready});
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_seq = 10'b1101001010;
        load_valid = 1'b1; pData = 8'hA5;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if ({sOut, busy, done, load_ready} !== {exp_seq[9-i], 1'b1, i == 9, i == 9})
                $display("FAIL single_frame cyc %0d: got %b want %b", i,
                         {sOut, busy, done, load_ready}, {exp_seq[9-i], 1'b1, i == 9, i == 9});
            else n_pass++;
            step();
        end
        #1;
        n_checks++;
        if ({sOut, busy, done, load_ready} !== 4'b0001)
            $display("FAIL single_frame_idle: got %b want 0001", {sOut, busy, done, load_ready});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        logic [3:0] want;
        load_valid = 1'b1; pData = 8'hFF;
        step();
        pData = 8'h00;
        for (int i = 0; i < 20; i++) begin
            #1;
            want = {frame_bit((i < 10) ? 32'hFF : 32'h00, i % 10, 8), 1'b1, (i % 10) == 9, (i % 10) == 9};
            n_checks++;
            if ({sOut, busy, done, load_ready} !== want)
                $display("FAIL back_to_back cyc %0d: got %b want %b", i, {sOut, busy, done, load_ready}, want);
            else n_pass++;
            if (done === 1'b1) done_cnt++;
            if (i == 10) load_valid = 1'b0;
            step();
        end
        n_checks++;
        if (done_cnt !== 2) $display("FAIL back_to_back_done_count: got %0d want 2", done_cnt);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        logic [19:0] seq = 20'd0;
        load_valid = 1'b1; pData = 8'hC3;
        step();
        for (int c = 0; c < 20; c++) begin
            if (c == 0) load_valid = 1'b0;
            if (c == 3) begin load_valid = 1'b1; pData = 8'h3C; end
            if (c == 10) load_valid = 1'b0;
            #1;
            seq = {seq[18:0], sOut};
            n_checks++;
            if ({sOut, busy, done, load_ready} !== {m_sout, m_busy, m_done, m_ready()})
                $display("FAIL ignore_busy cyc %0d: got %b want %b", c,
                         {sOut, busy, done, load_ready}, {m_sout, m_busy, m_done, m_ready()});
            else n_pass++;
            step();
        end
        n_checks++;
        if (seq !== 20'b11100001101001111000)
            $display("FAIL ignore_busy_seq: got %b want 11100001101001111000", seq);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        load_valid = 1'b1; pData = 8'hA5;
        step();
        load_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (load_ready !== 1'b0) $display("FAIL reset_mid_ready_in_rst: got %b want 0", load_ready);
        else n_pass++;
        step();
        n_checks++;
        if ({sOut, busy, done} !== 3'b000) $display("FAIL reset_mid_abort: got %b want 000", {sOut, busy, done});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (load_ready !== 1'b1) $display("FAIL reset_mid_release_ready: got %b want 1", load_ready);
        else n_pass++;
        step();
        n_checks++;
        if ({sOut, busy, done, load_ready} !== 4'b0001)
            $display("FAIL reset_mid_idle: got %b want 0001", {sOut, busy, done, load_ready});
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!load_valid || m_acc) begin
                load_valid = ($urandom_range(0, 2) != 0);
                pData = 8'($urandom);
            end
            #1;
            n_checks++;
            if ({sOut, busy, done, load_ready} !== {m_sout, m_busy, m_done, m_ready()})
                $display("FAIL random cyc %0d: got %b want %b", c,
                         {sOut, busy, done, load_ready}, {m_sout, m_busy, m_done, m_ready()});
            else n_pass++;
            step();
        end
        rst = 1'b0; load_valid = 1'b0;
        for (int c = 0; c < 12; c++) step();
    endtask

    task automatic test_width4();
        logic [5:0] exp_seq = 6'b110010;
        load_valid4 = 1'b1; pData4 = 4'h9;
        #1;
        n_checks++;
        if (load_ready4 !== 1'b1) $display("FAIL w4_ready: got %b want 1", load_ready4);
        else n_pass++;
        step();
        load_valid4 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if ({sOut4, busy4, done4} !== {exp_seq[5-c], 1'b1, c == 5})
                $display("FAIL w4_frame cyc %0d: got %b want %b", c, {sOut4, busy4, done4},
                         {exp_seq[5-c], 1'b1, c == 5});
            else n_pass++;
            step();
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if ({sOut4, busy4, done4, load_ready4} !== 4'b0001)
                $display("FAIL w4_idle cyc %0d: got %b want 0001", c, {sOut4, busy4, done4, load_ready4});
            else n_pass++;
            step();
        end
    endtask

    initial begin
        m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_acc = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        test_width4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
